// File: rtl/dmux8way_pkg.sv
// Shared constants and occupancy state encoding for the 8-way dispatch demux.
package dmux8way_pkg;

  localparam int unsigned N_OUT = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/dmux8way_dec.sv
// Combinational 3-to-8 one-hot decoder; all-zero output when en is low.
module dmux8way_dec
  import dmux8way_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N_OUT-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/dmux8way_dispatch.sv
// 2-entry in-order FIFO that offers each word to one of eight destinations
// selected by its stored index; the head blocks until its destination accepts.
module dmux8way_dispatch
  import dmux8way_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [SEL_W-1:0] in_sel,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  output logic [DW-1:0]    out_data,
  output logic             busy
);

  occ_state_t       state_q, state_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]    mem_data [2];
  logic [SEL_W-1:0] mem_sel  [2];

  logic             push, pop, nonempty;
  logic [SEL_W-1:0] head_sel;
  logic [DW-1:0]    head_data;

  assign nonempty  = (state_q != EMPTY);
  assign in_ready  = (state_q != TWO);
  assign busy      = nonempty;
  assign head_sel  = mem_sel[rd_ptr_q];
  assign head_data = mem_data[rd_ptr_q];
  assign out_data  = nonempty ? head_data : '0;

  dmux8way_dec u_dec (
    .sel (head_sel),
    .en  (nonempty),
    .y   (out_valid)
  );

  // out_valid is one-hot on the head select, so only that ready bit can pop.
  assign push = in_valid & in_ready;
  assign pop  = |(out_valid & out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload storage carries no reset; validity comes from the FSM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_sel[wr_ptr_q]  <= in_sel;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = TWO;
        else if (pop && !push) state_d = EMPTY;
      end
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_dmux8way_dispatch.sv
// Directed self-checking bench for dmux8way_dispatch.
module tb_dmux8way_dispatch;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2:0]    in_sel;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  dmux8way_dispatch #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [DW-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 8'h00;
    drive(1'b1, 3'd5, 16'h1234);

    // Reset held with in_valid asserted
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'h00);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    check("rst_out_data",  32'(out_data),  32'h0);
    drive(1'b0, 3'd0, 16'h0);
    #3 rst_n = 1'b1;
    step();
    check("rel_out_valid", 32'(out_valid), 32'h00);
    check("rel_busy",      32'(busy),      32'h0);

    // Single word
    out_ready = 8'hFF;
    drive(1'b1, 3'd5, 16'hBEEF);
    step();
    drive(1'b0, 3'd0, 16'h0);
    check("single_valid", 32'(out_valid), 32'h20);
    check("single_data",  32'(out_data),  32'hBEEF);
    check("single_busy",  32'(busy),      32'h1);
    step();
    check("single_busy_fall", 32'(busy),      32'h0);
    check("single_drained",   32'(out_valid), 32'h00);

    // Backpressure
    out_ready = 8'h00;
    drive(1'b1, 3'd2, 16'h0001);
    step();
    drive(1'b1, 3'd6, 16'h0002);
    step();
    check("bp_in_ready_full", 32'(in_ready),  32'h0);
    check("bp_head_valid",    32'(out_valid), 32'h04);
    check("bp_head_data",     32'(out_data),  32'h0001);
    drive(1'b1, 3'd7, 16'h0003);
    step();
    drive(1'b0, 3'd0, 16'h0);
    check("bp_third_refused", 32'(in_ready),  32'h0);
    check("bp_head_stable",   32'(out_valid), 32'h04);
    out_ready = 8'h04;
    step();
    check("bp_pop1_valid", 32'(out_valid), 32'h40);
    check("bp_pop1_data",  32'(out_data),  32'h0002);
    check("bp_pop1_ready", 32'(in_ready),  32'h1);
    out_ready = 8'h40;
    step();
    check("bp_no_third", 32'(out_valid), 32'h00);
    check("bp_empty",    32'(busy),      32'h0);

    // Head-of-line blocking
    out_ready = 8'h01;
    drive(1'b1, 3'd3, 16'h0A0A);
    step();
    drive(1'b1, 3'd0, 16'h0B0B);
    step();
    drive(1'b0, 3'd0, 16'h0);
    check("hol_valid", 32'(out_valid), 32'h08);
    check("hol_data",  32'(out_data),  32'h0A0A);
    step(); step();
    check("hol_still_blocked", 32'(out_valid), 32'h08);
    check("hol_still_data",    32'(out_data),  32'h0A0A);
    out_ready = 8'h08;
    step();
    check("hol_second_valid", 32'(out_valid), 32'h01);
    check("hol_second_data",  32'(out_data),  32'h0B0B);
    out_ready = 8'h01;
    step();
    check("hol_drained", 32'(busy), 32'h0);

    // Streaming with no bubbles
    out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 16'(16'h1000 + i));
      step();
      check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'(8'h01 << i));
      check($sformatf("stream_data_%0d", i),  32'(out_data),  32'(16'h1000 + i));
    end
    drive(1'b0, 3'd0, 16'h0);
    step();
    check("stream_drained", 32'(busy), 32'h0);

    // Full with simultaneous pop still refuses the new word
    out_ready = 8'h00;
    drive(1'b1, 3'd1, 16'h0011);
    step();
    drive(1'b1, 3'd4, 16'h0044);
    step();
    drive(1'b1, 3'd7, 16'h0077);
    out_ready = 8'h02;
    step();
    check("full_pop_valid", 32'(out_valid), 32'h10);
    check("full_pop_data",  32'(out_data),  32'h0044);
    check("full_pop_ready", 32'(in_ready),  32'h1);
    out_ready = 8'h00;
    step();
    drive(1'b0, 3'd0, 16'h0);
    check("refill_full", 32'(in_ready), 32'h0);

    // Asynchronous reset in state TWO
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h00);
    check("arst_busy",      32'(busy),      32'h0);
    check("arst_in_ready",  32'(in_ready),  32'h1);
    check("arst_out_data",  32'(out_data),  32'h0);
    #1 rst_n = 1'b1;
    out_ready = 8'hFF;
    step();
    check("arst_no_stale", 32'(out_valid), 32'h00);
    drive(1'b1, 3'd0, 16'h5A5A);
    step();
    drive(1'b0, 3'd0, 16'h0);
    check("post_rst_valid", 32'(out_valid), 32'h01);
    check("post_rst_data",  32'(out_data),  32'h5A5A);
    step();
    check("post_rst_drained", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
